// File: rtl/trumpet_compressor.sv
// -----------------------------------------------------------------------------
// trumpet_compressor
//
// Peak-envelope dynamics compressor that follows the noise gate. Each accepted
// sample goes through four phases:
//   IDLE : waits for a sample. With enable = 0 the sample is passed straight
//          through with one cycle of latency.
//   ENV  : updates the peak envelope. The attack rate is used when the sample
//          magnitude is above the envelope and the release rate otherwise.
//   DIV  : computes the gain in Q1.15 with a 16-cycle restoring divider. It
//          always takes the full 16 cycles, so latency is fixed.
//   MUL  : multiplies the sample by the gain and registers the result.
// Compressed samples appear 18 clocks after acceptance.
//
// Ports
//   clk         in   system clock; all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   1 = compress, 0 = bypass; sampled only in IDLE
//   in_sample   in   signed PCM sample from the noise gate
//   in_valid    in   in_sample is valid this cycle
//   in_ready    out  sample is accepted this cycle (high exactly in IDLE)
//   out_sample  out  processed sample, held between updates
//   out_valid   out  single-cycle strobe marking a new out_sample
//   gain_out    out  last applied gain, Q1.15 (0x8000 = 1.0)
// -----------------------------------------------------------------------------
module trumpet_compressor #(
    parameter int DATA_W        = 16,
    parameter int THRESHOLD     = 8000,
    parameter int RATIO_SHIFT   = 2,
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_valid,
    output logic [15:0]              gain_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENV  = 2'd1,
        S_DIV  = 2'd2,
        S_MUL  = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] THR       = DATA_W'(THRESHOLD);
    localparam logic [15:0]       GAIN_ONE  = 16'h8000;
    localparam logic [3:0]        DIV_LAST  = 4'd15;

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   sample_q, sample_d;
    logic [DATA_W-1:0]          env_q, env_d;
    // Divider: partial remainder (one bit wider than env so that the
    // left shift never overflows), quotient, and iteration counter.
    logic [DATA_W:0]            rem_q, rem_d;
    logic [15:0]                quo_q, quo_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       unity_q, unity_d;
    logic signed [DATA_W-1:0]   out_sample_q, out_sample_d;
    logic                       out_valid_q, out_valid_d;
    logic [15:0]                gain_q, gain_d;

    logic [DATA_W-1:0]          env_next;
    logic [DATA_W:0]            divisor;
    logic [15:0]                gain_sel;

    // Magnitude with saturation: the most negative code maps to max positive.
    function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] mag;
        if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
            mag = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (x < 0) begin
            mag = $unsigned(-x);
        end else begin
            mag = $unsigned(x);
        end
        return mag;
    endfunction

    // One envelope step. The result always lies between env and a, so the
    // unsigned add/subtract cannot wrap.
    function automatic logic [DATA_W-1:0] env_step(input logic [DATA_W-1:0] env,
                                                   input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] nxt;
        if (a > env) begin
            nxt = env + ((a - env) >> ATTACK_SHIFT);
        end else begin
            nxt = env - ((env - a) >> RELEASE_SHIFT);
        end
        return nxt;
    endfunction

    // Output level the envelope is pulled down to. Only meaningful when
    // env > THR; otherwise the unity flag overrides the quotient.
    function automatic logic [DATA_W-1:0] target_of(input logic [DATA_W-1:0] env);
        return THR + ((env - THR) >> RATIO_SHIFT);
    endfunction

    // Sample times Q1.15 gain, floored by the arithmetic shift. The gain is at
    // most 1.0, so the result always fits back into DATA_W bits.
    function automatic logic signed [DATA_W-1:0] apply_gain(input logic signed [DATA_W-1:0] s,
                                                            input logic [15:0] g);
        logic signed [DATA_W+16:0] prod;
        prod = s * $signed({1'b0, g});
        return DATA_W'(prod >>> 15);
    endfunction

    assign in_ready   = (state_q == S_IDLE);
    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign gain_out   = gain_q;

    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        env_d        = env_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        cnt_d        = cnt_q;
        unity_d      = unity_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        gain_d       = gain_q;
        env_next     = env_step(env_q, sat_abs(sample_q));
        divisor      = {1'b0, env_q};
        gain_sel     = unity_q ? GAIN_ONE : quo_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (enable) begin
                        sample_d = in_sample;
                        state_d  = S_ENV;
                    end else begin
                        out_sample_d = in_sample;
                        out_valid_d  = 1'b1;
                    end
                end
            end

            S_ENV: begin
                env_d   = env_next;
                unity_d = (env_next <= THR);
                // The divider starts from the dividend target. The first
                // iteration yields the integer bit (bit 15) of target/env,
                // so 16 iterations produce floor(target * 2^15 / env).
                rem_d   = {1'b0, target_of(env_next)};
                quo_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
            end

            S_DIV: begin
                if (rem_q >= divisor) begin
                    rem_d = (rem_q - divisor) << 1;
                    quo_d = {quo_q[14:0], 1'b1};
                end else begin
                    rem_d = rem_q << 1;
                    quo_d = {quo_q[14:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == DIV_LAST) begin
                    state_d = S_MUL;
                end
            end

            S_MUL: begin
                out_sample_d = apply_gain(sample_q, gain_sel);
                gain_d       = gain_sel;
                out_valid_d  = 1'b1;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sample_q     <= '0;
            env_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
            unity_q      <= 1'b0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            gain_q       <= GAIN_ONE;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            env_q        <= env_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            cnt_q        <= cnt_d;
            unity_q      <= unity_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            gain_q       <= gain_d;
        end
    end

endmodule

// File: tb/tb_trumpet_compressor.sv
// -----------------------------------------------------------------------------
// tb_trumpet_compressor
//
// Self-checking bench for trumpet_compressor. A behavioural model (direct
// integer division) predicts each result when a sample is driven and pushes
// it to a queue. The entry is popped and compared when out_valid appears.
// -----------------------------------------------------------------------------
module tb_trumpet_compressor;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] in_sample = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic [15:0]        gain_out;

    typedef struct packed {
        logic signed [15:0] s;
        logic [15:0]        g;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   env_m  = 0;
    int   gain_m = 32768;

    trumpet_compressor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .gain_out   (gain_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model for one accepted sample.
    task automatic model_push(input int s, input bit en);
        int     a;
        int     tgt;
        int     g;
        longint p;
        exp_t   e;
        if (!en) begin
            e.s = 16'(s);
            e.g = 16'(gain_m);
        end else begin
            a = (s < 0) ? -s : s;
            if (a > 32767) a = 32767;
            if (a > env_m) env_m = env_m + ((a - env_m) >> 2);
            else           env_m = env_m - ((env_m - a) >> 8);
            if (env_m <= 8000) begin
                g = 32768;
            end else begin
                tgt = 8000 + ((env_m - 8000) >> 2);
                g   = (tgt * 32768) / env_m;
            end
            p      = longint'(s) * longint'(g);
            p      = p >>> 15;
            e.s    = 16'(p);
            e.g    = 16'(g);
            gain_m = g;
        end
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        env_m    = 0;
        gain_m   = 32768;
        q.delete();
    endtask

    // Drives one compressed sample and waits for the result. lat is the
    // number of clocks from acceptance to out_valid, or -1 on timeout.
    task automatic compress_one(input int s, output int lat);
        lat = -1;
        for (int i = 0; i < 40 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        enable    = 1'b1;
        in_sample = 16'(s);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        model_push(s, 1'b1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_sample !== 16'sd0) begin errors++; $display("FAIL reset_out_sample: got %0d expected 0", out_sample); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (gain_out !== 16'h8000) begin errors++; $display("FAIL reset_gain: got %h expected 8000", gain_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_below_threshold();
        int   lat;
        exp_t e;
        compress_one(1000, lat);
        e = q.pop_front();
        checks++; if (lat !== 18) begin errors++; $display("FAIL below_latency: got %0d expected 18", lat); end
        checks++; if (out_sample !== e.s) begin errors++; $display("FAIL below_out: got %0d expected %0d", out_sample, e.s); end
        checks++; if (gain_out !== e.g) begin errors++; $display("FAIL below_gain: got %0d expected %0d", gain_out, e.g); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL below_strobe_width: got %b expected 0", out_valid); end
    endtask

    task automatic test_attack();
        int   lat;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            compress_one(20000, lat);
            e = q.pop_front();
            checks++; if (lat !== 18) begin errors++; $display("FAIL attack_latency[%0d]: got %0d expected 18", k, lat); end
            checks++; if (out_sample !== e.s) begin errors++; $display("FAIL attack_out[%0d]: got %0d expected %0d", k, out_sample, e.s); end
            checks++; if (gain_out !== e.g) begin errors++; $display("FAIL attack_gain[%0d]: got %0d expected %0d", k, gain_out, e.g); end
        end
    endtask

    task automatic test_reset_mid_div();
        int   lat;
        exp_t e;
        enable    = 1'b1;
        in_sample = 16'sd30000;
        in_valid  = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++; if (out_sample !== 16'sd0) begin errors++; $display("FAIL middiv_out_sample: got %0d expected 0", out_sample); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL middiv_out_valid: got %b expected 0", out_valid); end
        checks++; if (gain_out !== 16'h8000) begin errors++; $display("FAIL middiv_gain: got %h expected 8000", gain_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL middiv_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        env_m  = 0;
        gain_m = 32768;
        q.delete();
        compress_one(20000, lat);
        e = q.pop_front();
        checks++; if (out_sample !== e.s) begin errors++; $display("FAIL postreset_out: got %0d expected %0d", out_sample, e.s); end
        checks++; if (gain_out !== e.g) begin errors++; $display("FAIL postreset_gain: got %0d expected %0d", gain_out, e.g); end
    endtask

    task automatic test_neg_full_scale();
        int   lat;
        exp_t e;
        compress_one(-32768, lat);
        e = q.pop_front();
        checks++; if (lat !== 18) begin errors++; $display("FAIL negfs_latency: got %0d expected 18", lat); end
        checks++; if (out_sample !== e.s) begin errors++; $display("FAIL negfs_out: got %0d expected %0d", out_sample, e.s); end
        checks++; if (gain_out !== e.g) begin errors++; $display("FAIL negfs_gain: got %0d expected %0d", gain_out, e.g); end
    endtask

    task automatic test_handshake();
        int   last_acc;
        int   accepts;
        bit   drained;
        exp_t e;
        last_acc = -1;
        accepts  = 0;
        enable   = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            in_sample = 16'(12000 + c * 250);
            if (in_ready) begin
                model_push(12000 + c * 250, 1'b1);
                if (last_acc >= 0) begin
                    checks++;
                    if (c - last_acc !== 19) begin errors++; $display("FAIL hs_interval: got %0d expected 19", c - last_acc); end
                end
                last_acc = c;
                accepts++;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL hs_unexpected_output: got %0d expected none", out_sample);
                end else begin
                    e = q.pop_front();
                    if (out_sample !== e.s || gain_out !== e.g) begin
                        errors++;
                        $display("FAIL hs_result: got %0d/%0d expected %0d/%0d", out_sample, gain_out, e.s, e.g);
                    end
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (accepts !== 4) begin errors++; $display("FAIL hs_accepts: got %0d expected 4", accepts); end
        drained = (q.size() == 0);
        for (int n = 0; n < 40 && !drained; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                e = q.pop_front();
                checks++;
                if (out_sample !== e.s || gain_out !== e.g) begin
                    errors++;
                    $display("FAIL hs_drain: got %0d/%0d expected %0d/%0d", out_sample, gain_out, e.s, e.g);
                end
                drained = (q.size() == 0);
            end
        end
        checks++; if (!drained) begin errors++; $display("FAIL hs_drain_timeout: got %0d pending expected 0", q.size()); end
    endtask

    task automatic test_bypass();
        int   v[3];
        int   lat;
        exp_t e;
        v = '{5, -7, 300};
        @(posedge clk); #1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_sample = 16'(v[i]);
            in_valid  = 1'b1;
            model_push(v[i], 1'b0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL byp_ready[%0d]: got %b expected 1", i, in_ready); end
            @(posedge clk); #1;
            e = q.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_sample !== e.s) begin errors++; $display("FAIL byp_out[%0d]: got %0d expected %0d", i, out_sample, e.s); end
            checks++; if (gain_out !== e.g) begin errors++; $display("FAIL byp_gain[%0d]: got %0d expected %0d", i, gain_out, e.g); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL byp_idle_valid: got %b expected 0", out_valid); end
        // Envelope must be untouched by bypassed samples.
        compress_one(9000, lat);
        e = q.pop_front();
        checks++; if (out_sample !== e.s) begin errors++; $display("FAIL byp_env_out: got %0d expected %0d", out_sample, e.s); end
        checks++; if (gain_out !== e.g) begin errors++; $display("FAIL byp_env_gain: got %0d expected %0d", gain_out, e.g); end
    endtask

    task automatic test_enable_toggle();
        int   lat;
        exp_t e;
        enable    = 1'b1;
        in_sample = 16'sd25000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        model_push(25000, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        lat = -1;
        for (int n = 6; n <= 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        e = q.pop_front();
        checks++; if (lat !== 18) begin errors++; $display("FAIL toggle_latency: got %0d expected 18", lat); end
        checks++; if (out_sample !== e.s) begin errors++; $display("FAIL toggle_out: got %0d expected %0d", out_sample, e.s); end
        checks++; if (gain_out !== e.g) begin errors++; $display("FAIL toggle_gain: got %0d expected %0d", gain_out, e.g); end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_below_threshold();
        do_reset();
        test_attack();
        test_reset_mid_div();
        do_reset();
        test_neg_full_scale();
        do_reset();
        test_handshake();
        test_bypass();
        test_enable_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trumpet_compressor.md
# trumpet_compressor

Downstream dynamics stage that follows the noise gate in the trumpet signal chain. It consumes gated 16-bit PCM samples, tracks a peak envelope with separate attack and release rates, and computes a per-sample gain with a 16-cycle sequential divider. It applies that gain to the sample and presents the result to the output stage with a valid strobe. When disabled, it passes samples through with one cycle of latency.

## Interface
- THRESHOLD, 8000: envelope level above which compression applies (0..32767).
- RATIO_SHIFT, 2: compression ratio is 2^RATIO_SHIFT:1 above threshold.
- ATTACK_SHIFT, 2: rising-envelope smoothing shift.
- RELEASE_SHIFT, 8: falling-envelope smoothing shift.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = compress, 0 = bypass; sampled only in IDLE.
- in_sample  in  16 signed  gated sample from the noise gate.
- in_valid  in  1  in_sample is valid this cycle.
- in_ready  out  1  block accepts a sample this cycle; high exactly when in IDLE.
- out_sample  out  16 signed  processed sample; held between updates.
- out_valid  out  1  single-cycle strobe; out_sample is new this cycle. No backpressure.
- gain_out  out  16 unsigned  last applied gain, Q1.15, 0x8000 = 1.0.

## Operation
- The clock is named clk. Reset is asynchronous and active-low, and is named rst_n.
- Reset state:
  - state = IDLE, env = 0.
  - out_sample = 0, out_valid = 0, gain_out = 0x8000.
  - Divider registers = 0.
- States: IDLE, ENV, DIV, MUL.
- Acceptance happens on an edge where state = IDLE and in_valid = 1.
  - If enable = 1: latch the sample and go to ENV.
  - If enable = 0 (bypass): out_sample <= in_sample and out_valid <= 1. Stay in IDLE; env and gain_out are unchanged.
- in_valid while not in IDLE is ignored (sample dropped, no error).
- ENV (1 cycle):
  - a = |sample|, saturated: -32768 gives 32767.
  - If a > env: env <= env + ((a - env) >> ATTACK_SHIFT).
  - Otherwise: env <= env - ((env - a) >> RELEASE_SHIFT).
  - All arithmetic is unsigned with floor.
  - Go to DIV.
- DIV (exactly 16 cycles, always, so latency is fixed):
  - If env <= THRESHOLD: gain = 0x8000.
  - Otherwise: target = THRESHOLD + ((env - THRESHOLD) >> RATIO_SHIFT), and gain = floor(target * 32768 / env).
  - The division is restoring division, one quotient bit per cycle. Because target < env, gain < 32768.
  - Go to MUL.
- MUL (1 cycle):
  - prod = sample * gain, computed as a 33-bit signed product.
  - out_sample <= prod >>> 15 (arithmetic shift, floor). gain <= 1.0, so no saturation is needed.
  - gain_out <= gain, out_valid <= 1, then go to IDLE.
- out_valid is 0 on every cycle that is not an update.
- enable changing while busy does not affect the in-flight sample.
- Reset asserted mid-operation immediately clears all state; the in-flight sample is discarded.

## Timing
- Compress path:
  - Acceptance edge E0.
  - ENV completes at E1.
  - DIV occupies E2..E17.
  - MUL result registers at E18, so out_valid is high for the cycle after E18.
  - Latency is 18 clocks.
- Throughput in compress mode: next acceptance at E19 at the earliest (in_ready high from E18).
- Bypass: out_valid is high for the cycle after the acceptance edge; latency 1. A new sample can be accepted every cycle.
- in_ready is combinational from state only (not from in_valid).

## Test plan
- Reset: hold rst_n = 0 mid-DIV with samples flowing, then release.
  - out_sample = 0, out_valid = 0, gain_out = 0x8000, in_ready = 1.
  - The next sample behaves as if env = 0.
- Below threshold, enable = 1, env = 0, in_sample = 1000.
  - env = 250, out_sample = 1000, gain_out = 0x8000.
  - out_valid arrives exactly 18 clocks after acceptance.
- Attack step, enable = 1, env = 0, two samples of 20000.
  - First sample: env = 5000, out_sample = 20000.
  - Second sample: env = 8750, target = 8187, gain_out = 30659, out_sample = 18712.
- Negative full scale: env = 0, in_sample = -32768.
  - a = 32767, env = 8191, target = 8047, gain_out = 32191, out_sample = -32191.
- Handshake: hold in_valid = 1 continuously with enable = 1.
  - Exactly one sample is accepted per 19 clocks.
  - in_ready = 0 during ENV/DIV/MUL; intermediate samples are dropped.
- Bypass: enable = 0, stream 5, -7, 300 on consecutive cycles.
  - Outputs are 5, -7, 300, each one clock later with out_valid high.
  - env and gain_out are unchanged.
  - Toggling enable while in DIV does not alter that sample's result.
